// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM state encoding and opcode decode helpers shared by
// mult_div_unit and its controller.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_controller.sv
// mdu_controller: sequencing FSM for mult_div_unit. Owns the iteration counter
// and derives busy/valid from state. MDU_EARLY_TERM_EN exposes the counter.
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          div_zero_i,
    input  logic          mul_zero_i,
    input  logic          early_exit_i,
    output mdu_state_e    state_o,
    output logic          accept_o,
    output logic          busy_o,
`ifdef MDU_EARLY_TERM_EN
    output logic [CW-1:0] cnt_o,
`endif
    output logic          valid_o
);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    cnt_d    = CW'(W - 1);
                    if (div_zero_i)
                        state_d = S_DONE;
                    else if (mul_zero_i)
                        state_d = S_FIX;
                    else
                        state_d = S_CALC;
                end
            end
            S_CALC: begin
                if ((cnt_q == '0) || early_exit_i)
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o = state_q;
    assign busy_o  = (state_q == S_CALC) || (state_q == S_FIX);
    assign valid_o = (state_q == S_DONE);
`ifdef MDU_EARLY_TERM_EN
    assign cnt_o   = cnt_q;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed/unsigned multiply and divide with HI/LO
// result registers. Optional MDU_EARLY_TERM_EN shortens multiplies.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  valid,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    mdu_state_e     state;
    logic           accept, div_zero, mul_zero, early_exit;
    logic           div_op, sgn_op;
    logic [W-1:0]   mag1, mag2;

    logic           div_q, div_d;
    logic           res_neg_q, res_neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           dbz_q, dbz_d;

    logic [W:0]     mul_sum;
    logic [W+1:0]   div_shift, div_diff;
    logic [2*W-1:0] prod;

    assign div_op   = is_div(op);
    assign sgn_op   = is_signed(op);
    assign mag1     = (sgn_op && Operand1[W-1]) ? -Operand1 : Operand1;
    assign mag2     = (sgn_op && Operand2[W-1]) ? -Operand2 : Operand2;
    assign div_zero = div_op && (Operand2 == '0);

`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0]  mpl_q, mpl_d;
    logic [CW-1:0] skip_q, skip_d;
    logic [CW-1:0] cnt;

    // Shadow of the multiplier magnitude: once its unconsumed bits are zero the
    // remaining iterations would only shift, so FIX does that shift in one go.
    assign mul_zero   = !div_op && (Operand2 == '0);
    assign early_exit = (state == S_CALC) && !div_q && ((mpl_q >> 1) == '0);
    assign prod       = acc_q >> skip_q;

    always_comb begin
        mpl_d  = mpl_q;
        skip_d = skip_q;
        if (accept) begin
            mpl_d  = mag2;
            skip_d = '0;
        end else if (state == S_CALC) begin
            mpl_d = mpl_q >> 1;
            if (early_exit)
                skip_d = cnt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mpl_q  <= '0;
            skip_q <= '0;
        end else begin
            mpl_q  <= mpl_d;
            skip_q <= skip_d;
        end
    end
`else
    assign mul_zero   = 1'b0;
    assign early_exit = 1'b0;
    assign prod       = acc_q;
`endif

    mdu_controller #(
        .W  (W),
        .CW (CW)
    ) u_ctrl (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .start_i      (start),
        .div_zero_i   (div_zero),
        .mul_zero_i   (mul_zero),
        .early_exit_i (early_exit),
        .state_o      (state),
        .accept_o     (accept),
        .busy_o       (busy),
`ifdef MDU_EARLY_TERM_EN
        .cnt_o        (cnt),
`endif
        .valid_o      (valid)
    );

    // Multiply: add into the upper half, then shift the whole accumulator right.
    // Divide: the low half shifts the dividend out and the quotient in, while the
    // extra MSB of the subtraction is the borrow that selects restore.
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {rem_q, acc_q[W-1]};
    assign div_diff  = div_shift - {2'b00, opnd_q};

    always_comb begin
        div_d     = div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        if (accept) begin
            div_d     = div_op;
            res_neg_d = sgn_op && (Operand1[W-1] ^ Operand2[W-1]);
            rem_neg_d = sgn_op && Operand1[W-1];
            opnd_d    = div_op ? mag2 : mag1;
            acc_d     = {{W{1'b0}}, (div_op ? mag1 : mag2)};
            rem_d     = '0;
            dbz_d     = 1'b0;
            if (div_zero) begin
                hi_d  = Operand1;
                lo_d  = '1;
                dbz_d = 1'b1;
            end
        end else if (state == S_CALC) begin
            if (div_q) begin
                rem_d          = div_diff[W+1] ? div_shift[W:0] : div_diff[W:0];
                acc_d[W-1:0]   = {acc_q[W-2:0], ~div_diff[W+1]};
            end else begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end
        end else if (state == S_FIX) begin
            if (div_q) begin
                lo_d = res_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                hi_d = rem_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
            end else begin
                {hi_d, lo_d} = res_neg_q ? -prod : prod;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q     <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
